// File: rtl/fill_run_compressor.sv
// fill_run_compressor - folds runs of all-0/all-1 words into (bit, length) tokens, other words pass as literals.
// One output register plus a one-token hold buffer for the cycle where a run closes and a second token is due.
module fill_run_compressor #(
   parameter int W     = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_kind,
   output logic             out_bit,
   output logic [CNT_W-1:0] out_len,
   output logic [W-1:0]     out_data,
   output logic             out_last
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   typedef struct packed {
      logic             kind;
      logic             fbit;
      logic [CNT_W-1:0] len;
      logic [W-1:0]     data;
      logic             last;
   } tok_t;

   localparam logic [CNT_W-1:0] MAX_LEN = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic             run_bit_q, run_bit_d;
   logic [CNT_W-1:0] run_len_q, run_len_d;
   tok_t             hold_q, hold_d;
   tok_t             out_q;
   logic             out_valid_q;

   logic             slot_free, accept, is_fill, fill_bit, emit;
   tok_t             emit_tok;

   function automatic tok_t run_tok(input logic b, input logic [CNT_W-1:0] n, input logic l);
      tok_t t;
      t      = '0;
      t.kind = 1'b1;
      t.fbit = b;
      t.len  = n;
      t.last = l;
      return t;
   endfunction

   function automatic tok_t lit_tok(input logic [W-1:0] d, input logic l);
      tok_t t;
      t      = '0;
      t.data = d;
      t.last = l;
      return t;
   endfunction

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = slot_free && (state_q != PEND);
   assign accept    = in_valid && in_ready;
   assign is_fill   = (&in_data) || !(|in_data);
   assign fill_bit  = in_data[0];

   always_comb begin
      state_d   = state_q;
      run_bit_d = run_bit_q;
      run_len_d = run_len_q;
      hold_d    = hold_q;
      emit      = 1'b0;
      emit_tok  = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               emit = 1'b1;
               if (!is_fill) begin
                  emit_tok = lit_tok(in_data, in_last);
               end else if (in_last) begin
                  emit_tok = run_tok(fill_bit, ONE, 1'b1);
               end else begin
                  emit      = 1'b0;
                  state_d   = RUN;
                  run_bit_d = fill_bit;
                  run_len_d = ONE;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (is_fill && fill_bit == run_bit_q) begin
                  if (run_len_q != MAX_LEN) begin
                     if (in_last) begin
                        emit      = 1'b1;
                        emit_tok  = run_tok(run_bit_q, run_len_q + ONE, 1'b1);
                        state_d   = IDLE;
                        run_len_d = '0;
                     end else begin
                        run_len_d = run_len_q + ONE;
                     end
                  end else begin
                     // Full counter: close this token and restart the same run at length 1.
                     emit     = 1'b1;
                     emit_tok = run_tok(run_bit_q, MAX_LEN, 1'b0);
                     if (in_last) begin
                        hold_d    = run_tok(run_bit_q, ONE, 1'b1);
                        state_d   = PEND;
                        run_len_d = '0;
                     end else begin
                        run_len_d = ONE;
                     end
                  end
               end else begin
                  emit     = 1'b1;
                  emit_tok = run_tok(run_bit_q, run_len_q, 1'b0);
                  if (is_fill && !in_last) begin
                     run_bit_d = fill_bit;
                     run_len_d = ONE;
                  end else begin
                     hold_d    = is_fill ? run_tok(fill_bit, ONE, 1'b1) : lit_tok(in_data, in_last);
                     state_d   = PEND;
                     run_len_d = '0;
                  end
               end
            end
         end
         PEND: begin
            if (slot_free) begin
               emit     = 1'b1;
               emit_tok = hold_q;
               hold_d   = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         run_bit_q   <= 1'b0;
         run_len_q   <= '0;
         hold_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_bit_q <= run_bit_d;
         run_len_q <= run_len_d;
         hold_q    <= hold_d;
         if (emit) begin
            out_q       <= emit_tok;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_kind  = out_q.kind;
   assign out_bit   = out_q.fbit;
   assign out_len   = out_q.len;
   assign out_data  = out_q.data;
   assign out_last  = out_q.last;

endmodule

// File: tb/tb_fill_run_compressor.sv
// tb/tb_fill_run_compressor.sv - bench for fill_run_compressor (W=4/CNT_W=2 and W=1/CNT_W=3 instances).
module tb_fill_run_compressor;

   localparam int MAXL = 3;

   typedef struct packed {
      logic       kind;
      logic       fbit;
      logic [1:0] len;
      logic [3:0] data;
      logic       last;
   } tok_t;

   typedef struct packed {
      logic [3:0] d;
      logic       l;
   } word_t;

   typedef struct {
      int              nw;
      word_t [7:0]     w;
      int              nt;
      tok_t  [7:0]     t;
   } tc_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, in_ready, in_last = 1'b0;
   logic [3:0] in_data = '0;
   logic       out_valid, out_ready = 1'b1, out_kind, out_bit, out_last;
   logic [1:0] out_len;
   logic [3:0] out_data;

   logic       v1_in_valid = 1'b0, v1_in_ready, v1_in_last = 1'b0;
   logic [0:0] v1_in_data = '0;
   logic       v1_out_valid, v1_out_ready = 1'b1, v1_out_kind, v1_out_bit, v1_out_last;
   logic [2:0] v1_out_len;
   logic [0:0] v1_out_data;

   int n_cmp = 0, n_bad = 0;
   tok_t  got[$], exp_q[$];
   word_t ref_in[$];
   logic [31:0] got1[$];
   logic  stall_prev = 1'b0;
   tok_t  prev_tok;
   bit    bp_on;
   tc_t   tc[7];

   always #5 clk = ~clk;

   fill_run_compressor #(.W(4), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_bit(out_bit),
      .out_len(out_len), .out_data(out_data), .out_last(out_last)
   );

   fill_run_compressor #(.W(1), .CNT_W(3)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_data(v1_in_data), .in_last(v1_in_last),
      .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_kind(v1_out_kind), .out_bit(v1_out_bit),
      .out_len(v1_out_len), .out_data(v1_out_data), .out_last(v1_out_last)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic tok_t rt(input logic b, input int n, input logic l);
      tok_t t;
      t = '0; t.kind = 1'b1; t.fbit = b; t.len = 2'(n); t.last = l;
      return t;
   endfunction

   function automatic tok_t lt(input logic [3:0] d, input logic l);
      tok_t t;
      t = '0; t.data = d; t.last = l;
      return t;
   endfunction

   function automatic bit is_fill(input logic [3:0] d);
      return (d == 4'h0) || (d == 4'hF);
   endfunction

   // Tokens consumed at the coming edge are sampled mid-cycle; a stalled token must not change.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("hold_stable", {31'd0, out_valid} << 9 | 32'({out_kind, out_bit, out_len, out_data, out_last}),
                  {31'd0, 1'b1} << 9 | 32'(prev_tok));
         if (out_valid && out_ready) got.push_back({out_kind, out_bit, out_len, out_data, out_last});
         if (v1_out_valid && v1_out_ready) got1.push_back(32'({v1_out_kind, v1_out_bit, v1_out_len, v1_out_data, v1_out_last}));
         stall_prev = out_valid && !out_ready;
         prev_tok   = {out_kind, out_bit, out_len, out_data, out_last};
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got.delete();
   endtask

   task automatic send(input logic [3:0] d, input logic l, output int waits);
      in_data = d; in_last = l; in_valid = 1'b1; waits = 0;
      #2;
      while (!in_ready && waits <= 200) begin
         @(negedge clk); #2;
         waits++;
      end
      if (waits > 200) begin
         check("send_timeout", 32'(waits), 32'd0);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain_compare(input string nm);
      int cyc = 0;
      while (got.size() < exp_q.size() && cyc < 2000) begin
         @(negedge clk); cyc++;
      end
      repeat (4) @(negedge clk);
      check($sformatf("%s count", nm), 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s tok%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   task automatic ref_model();
      int i, n, cnt, rem, c;
      logic b, lst;
      exp_q.delete();
      n = ref_in.size();
      i = 0;
      while (i < n) begin
         if (!is_fill(ref_in[i].d)) begin
            exp_q.push_back(lt(ref_in[i].d, ref_in[i].l));
            i++;
         end else begin
            b = ref_in[i].d[0];
            cnt = 1;
            while (i + cnt < n && !ref_in[i+cnt-1].l && is_fill(ref_in[i+cnt].d) && ref_in[i+cnt].d[0] == b)
               cnt++;
            lst = ref_in[i+cnt-1].l;
            rem = cnt;
            while (rem > 0) begin
               c = (rem > MAXL) ? MAXL : rem;
               rem -= c;
               exp_q.push_back(rt(b, c, lst && rem == 0));
            end
            i += cnt;
         end
      end
   endtask

   task automatic aw(input int k, input logic [3:0] d, input logic l);
      tc[k].w[tc[k].nw] = {d, l};
      tc[k].nw++;
   endtask

   task automatic at(input int k, input tok_t t);
      tc[k].t[tc[k].nt] = t;
      tc[k].nt++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int k = 0; k < 7; k++) begin tc[k].nw = 0; tc[k].nt = 0; end
      aw(0, 4'hF, 0); aw(0, 4'hF, 0); aw(0, 4'hF, 1);
      at(0, rt(1, 3, 1));
      aw(1, 4'h0, 0); aw(1, 4'h0, 0); aw(1, 4'h5, 0); aw(1, 4'h3, 1);
      at(1, rt(0, 2, 0)); at(1, lt(4'h5, 0)); at(1, lt(4'h3, 1));
      for (int i = 0; i < 5; i++) aw(2, 4'h0, 0);
      aw(2, 4'hF, 1);
      at(2, rt(0, 3, 0)); at(2, rt(0, 2, 0)); at(2, rt(1, 1, 1));
      for (int i = 0; i < 3; i++) aw(3, 4'h0, 0);
      aw(3, 4'h0, 1);
      at(3, rt(0, 3, 0)); at(3, rt(0, 1, 1));
      aw(4, 4'h9, 1);
      at(4, lt(4'h9, 1));
      aw(5, 4'hF, 1); aw(5, 4'h0, 1); aw(5, 4'h6, 0); aw(5, 4'hF, 0); aw(5, 4'hF, 1);
      at(5, rt(1, 1, 1)); at(5, rt(0, 1, 1)); at(5, lt(4'h6, 0)); at(5, rt(1, 2, 1));
      for (int i = 0; i < 6; i++) aw(6, 4'hF, 0);
      aw(6, 4'h0, 1);
      at(6, rt(1, 3, 0)); at(6, rt(1, 3, 0)); at(6, rt(0, 1, 1));

      reset_dut();
      #2;
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset fields", 32'({out_kind, out_bit, out_len, out_data, out_last}), 32'd0);

      for (int k = 0; k < 7; k++) begin
         reset_dut();
         exp_q.delete();
         for (int i = 0; i < tc[k].nw; i++) send(tc[k].w[i].d, tc[k].w[i].l, w);
         for (int i = 0; i < tc[k].nt; i++) exp_q.push_back(tc[k].t[i]);
         drain_compare($sformatf("case%0d", k));
      end

      // Literal after a run parks one token: the next word stalls exactly one cycle.
      reset_dut();
      send(4'h0, 0, w); send(4'h0, 0, w);
      send(4'h5, 0, w);
      check("lit accept waits", 32'(w), 32'd0);
      send(4'h3, 1, w);
      check("pend stall cycles", 32'(w), 32'd1);
      exp_q.delete();
      exp_q.push_back(rt(0, 2, 0)); exp_q.push_back(lt(4'h5, 0)); exp_q.push_back(lt(4'h3, 1));
      drain_compare("pend");

      // Ten cycles of backpressure with a token waiting and another word offered.
      reset_dut();
      out_ready = 1'b0;
      send(4'h0, 0, w); send(4'h0, 0, w); send(4'h5, 0, w);
      in_data = 4'h3; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #2;
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp token", 32'({out_valid, out_kind, out_bit, out_len, out_data, out_last}),
               32'({1'b1, rt(0, 2, 0)}));
         @(negedge clk);
      end
      out_ready = 1'b1;
      send(4'h3, 1, w);
      exp_q.delete();
      exp_q.push_back(rt(0, 2, 0)); exp_q.push_back(lt(4'h5, 0)); exp_q.push_back(lt(4'h3, 1));
      drain_compare("bp");

      // Asynchronous reset while a run token is stalled and a new run is open.
      reset_dut();
      out_ready = 1'b0;
      send(4'h0, 0, w); send(4'hF, 0, w);
      #2;
      check("pre-reset valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async reset valid", 32'(out_valid), 32'd0);
      check("async reset fields", 32'({out_kind, out_bit, out_len, out_data, out_last}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      got.delete();
      send(4'hA, 1, w);
      exp_q.delete();
      exp_q.push_back(lt(4'hA, 1));
      drain_compare("after reset");

      // Randomized stream under random backpressure against the run-grouping model.
      reset_dut();
      ref_in.delete();
      for (int i = 0; i < 300; i++) begin
         int r;
         logic [3:0] d;
         r = $urandom_range(0, 4);
         d = (r <= 1) ? 4'h0 : (r <= 3) ? 4'hF : 4'($urandom_range(0, 15));
         ref_in.push_back({d, logic'(($urandom_range(0, 15) == 0) || i == 299)});
      end
      ref_model();
      bp_on = 1'b1;
      fork
         begin
            for (int i = 0; i < ref_in.size(); i++) send(ref_in[i].d, ref_in[i].l, w);
            bp_on = 1'b0;
         end
         begin
            while (bp_on) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain_compare("rand");

      // Single-bit words are always fill words.
      got1.delete();
      for (int i = 0; i < 3; i++) begin
         int c = 0;
         @(negedge clk);
         v1_in_data = (i < 2) ? 1'b1 : 1'b0;
         v1_in_last = (i == 2);
         v1_in_valid = 1'b1;
         #2;
         while (!v1_in_ready && c < 50) begin @(negedge clk); #2; c++; end
         check("w1 ready", 32'(v1_in_ready), 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      v1_in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("w1 count", 32'(got1.size()), 32'd2);
      if (got1.size() >= 2) begin
         check("w1 tok0", got1[0], 32'({1'b1, 1'b1, 3'd2, 1'b0, 1'b0}));
         check("w1 tok1", got1[1], 32'({1'b1, 1'b0, 3'd1, 1'b0, 1'b1}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
